// File: rtl/aes128_decrypt_core.sv
// Iterative AES-128 decryption: one round per cycle, round keys derived on the fly
// (forward expansion to round key 10, then the schedule is stepped backwards).

module mix_cols #(
   parameter bit INVERSE = 1'b0
) (
   input  logic [127:0] data_in,
   output logic [127:0] data_out
);

   // Row-0 coefficients; each later row is the same set rotated right by one.
   localparam logic [15:0] COEF = INVERSE ? 16'hebd9 : 16'h2311;

   function automatic logic [7:0] xt(input logic [7:0] b);
      return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
   endfunction

   function automatic logic [7:0] gmul(input logic [7:0] b, input logic [3:0] c);
      logic [7:0] p;
      logic [7:0] x;
      p = '0;
      x = b;
      for (int i = 0; i < 4; i++) begin
         if (c[i]) p = p ^ x;
         x = xt(x);
      end
      return p;
   endfunction

   function automatic logic [127:0] mix(input logic [127:0] s);
      logic [127:0] o;
      logic [7:0]   acc;
      o = '0;
      for (int c = 0; c < 4; c++) begin
         for (int i = 0; i < 4; i++) begin
            acc = '0;
            for (int j = 0; j < 4; j++)
               acc = acc ^ gmul(s[127 - 8*(j + 4*c) -: 8], COEF[15 - 4*((j + 4 - i) % 4) -: 4]);
            o[127 - 8*(i + 4*c) -: 8] = acc;
         end
      end
      return o;
   endfunction

   always_comb data_out = mix(data_in);

endmodule

module aes128_decrypt_core (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         in_valid,
   output logic         in_ready,
   input  logic [127:0] key_in,
   input  logic [127:0] data_in,
   output logic         out_valid,
   input  logic         out_ready,
   output logic [127:0] data_out
);

   localparam int unsigned BLK_W = 128;
   localparam int unsigned RC_W  = 4;
   localparam int unsigned FSM_W = 3;

   localparam logic [FSM_W-1:0] S_IDLE   = 3'd0;
   localparam logic [FSM_W-1:0] S_EXPAND = 3'd1;
   localparam logic [FSM_W-1:0] S_INIT   = 3'd2;
   localparam logic [FSM_W-1:0] S_ROUND  = 3'd3;
   localparam logic [FSM_W-1:0] S_FINAL  = 3'd4;
   localparam logic [FSM_W-1:0] S_DONE   = 3'd5;

   localparam logic [2047:0] SBOX = {
      128'h637c777bf26b6fc53001672bfed7ab76, 128'hca82c97dfa5947f0add4a2af9ca472c0,
      128'hb7fd9326363ff7cc34a5e5f171d83115, 128'h04c723c31896059a071280e2eb27b275,
      128'h09832c1a1b6e5aa0523bd6b329e32f84, 128'h53d100ed20fcb15b6acbbe394a4c58cf,
      128'hd0efaafb434d338545f9027f503c9fa8, 128'h51a3408f929d38f5bcb6da2110fff3d2,
      128'hcd0c13ec5f974417c4a77e3d645d1973, 128'h60814fdc222a908846eeb814de5e0bdb,
      128'he0323a0a4906245cc2d3ac629195e479, 128'he7c8376d8dd54ea96c56f4ea657aae08,
      128'hba78252e1ca6b4c6e8dd741f4bbd8b8a, 128'h703eb5664803f60e613557b986c11d9e,
      128'he1f8981169d98e949b1e87e9ce5528df, 128'h8ca1890dbfe6426841992d0fb054bb16};

   localparam logic [2047:0] INV_SBOX = {
      128'h52096ad53036a538bf40a39e81f3d7fb, 128'h7ce339829b2fff87348e4344c4dee9cb,
      128'h547b9432a6c2233dee4c950b42fac34e, 128'h082ea16628d924b2765ba2496d8bd125,
      128'h72f8f66486689816d4a45ccc5d65b692, 128'h6c704850fdedb9da5e154657a78d9d84,
      128'h90d8ab008cbcd30af7e45805b8b34506, 128'hd02c1e8fca3f0f02c1afbd0301138a6b,
      128'h3a9111414f67dcea97f2cfcef0b4e673, 128'h96ac7422e7ad3585e2f937e81c75df6e,
      128'h47f11a711d29c5896fb7620eaa18be1b, 128'hfc563e4bc6d279209adbc0fe78cd5af4,
      128'h1fdda8338807c731b11210592780ec5f, 128'h60517fa919b54a0d2de57a9f93c99cef,
      128'ha0e03b4dae2af5b0c8ebbb3c83539961, 128'h172b047eba77d626e169146355210c7d};

   // Entry b sits at bit 2047-8b, i.e. {~b, 3'b111}.
   function automatic logic [7:0] sbox(input logic [7:0] b);
      return SBOX[{~b, 3'b111} -: 8];
   endfunction

   function automatic logic [7:0] inv_sbox(input logic [7:0] b);
      return INV_SBOX[{~b, 3'b111} -: 8];
   endfunction

   function automatic logic [31:0] sub_rot(input logic [31:0] w);
      return {sbox(w[23:16]), sbox(w[15:8]), sbox(w[7:0]), sbox(w[31:24])};
   endfunction

   function automatic logic [7:0] rcon(input logic [RC_W-1:0] r);
      case (r)
         4'd1:    return 8'h01;
         4'd2:    return 8'h02;
         4'd3:    return 8'h04;
         4'd4:    return 8'h08;
         4'd5:    return 8'h10;
         4'd6:    return 8'h20;
         4'd7:    return 8'h40;
         4'd8:    return 8'h80;
         4'd9:    return 8'h1b;
         4'd10:   return 8'h36;
         default: return 8'h00;
      endcase
   endfunction

   // InvShiftRows (row r rotated right by r) followed by InvSubBytes.
   function automatic logic [BLK_W-1:0] inv_sr_sb(input logic [BLK_W-1:0] s);
      logic [BLK_W-1:0] o;
      o = '0;
      for (int c = 0; c < 4; c++)
         for (int r = 0; r < 4; r++)
            o[127 - 8*(r + 4*c) -: 8] = inv_sbox(s[127 - 8*(r + 4*((c + 4 - r) % 4)) -: 8]);
      return o;
   endfunction

   logic [FSM_W-1:0] fsm, fsm_nxt;
   logic [RC_W-1:0]  rc, rc_nxt;
   logic [BLK_W-1:0] rk, rk_nxt;
   logic [BLK_W-1:0] blk, blk_nxt;
   logic [BLK_W-1:0] dout_nxt;
   logic             ovalid_nxt;

   logic [31:0]      w1_b, w2_b, w3_b, sr_word, key_t;
   logic [31:0]      w0_f, w1_f, w2_f, w3_f;
   logic [BLK_W-1:0] key_f, key_b, isb, mix_in, mix_out;

   assign in_ready = (fsm == S_IDLE);

   // One shared SubWord(RotWord()) serves both schedule directions.
   assign w3_b    = rk[31:0]  ^ rk[63:32];
   assign w2_b    = rk[63:32] ^ rk[95:64];
   assign w1_b    = rk[95:64] ^ rk[127:96];
   assign sr_word = (fsm == S_EXPAND) ? rk[31:0] : w3_b;
   assign key_t   = sub_rot(sr_word) ^ {rcon(rc), 24'h0};
   assign w0_f    = rk[127:96] ^ key_t;
   assign w1_f    = rk[95:64]  ^ w0_f;
   assign w2_f    = rk[63:32]  ^ w1_f;
   assign w3_f    = rk[31:0]   ^ w2_f;
   assign key_f   = {w0_f, w1_f, w2_f, w3_f};
   assign key_b   = {rk[127:96] ^ key_t, w1_b, w2_b, w3_b};
   assign isb     = inv_sr_sb(blk);
   assign mix_in  = isb ^ key_b;

   mix_cols #(.INVERSE(1'b1)) u_inv_mix (
      .data_in  (mix_in),
      .data_out (mix_out)
   );

   always_comb begin
      fsm_nxt    = fsm;
      rc_nxt     = rc;
      rk_nxt     = rk;
      blk_nxt    = blk;
      dout_nxt   = data_out;
      ovalid_nxt = out_valid;
      case (fsm)
         S_IDLE: begin
            if (in_valid) begin
               rk_nxt  = key_in;
               blk_nxt = data_in;
               rc_nxt  = 4'd1;
               fsm_nxt = S_EXPAND;
            end
         end
         S_EXPAND: begin
            rk_nxt = key_f;
            if (rc == 4'd10) fsm_nxt = S_INIT;
            else             rc_nxt  = rc + 4'd1;
         end
         S_INIT: begin
            blk_nxt = blk ^ rk;
            rc_nxt  = 4'd10;
            fsm_nxt = S_ROUND;
         end
         S_ROUND: begin
            rk_nxt  = key_b;
            blk_nxt = mix_out;
            rc_nxt  = rc - 4'd1;
            if (rc == 4'd2) fsm_nxt = S_FINAL;
         end
         S_FINAL: begin
            rk_nxt     = key_b;
            blk_nxt    = mix_in;
            dout_nxt   = mix_in;
            ovalid_nxt = 1'b1;
            rc_nxt     = rc - 4'd1;
            fsm_nxt    = S_DONE;
         end
         S_DONE: begin
            if (out_ready) begin
               ovalid_nxt = 1'b0;
               fsm_nxt    = S_IDLE;
            end
         end
         default: fsm_nxt = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         fsm       <= S_IDLE;
         rc        <= '0;
         rk        <= '0;
         blk       <= '0;
         data_out  <= '0;
         out_valid <= 1'b0;
      end else begin
         fsm       <= fsm_nxt;
         rc        <= rc_nxt;
         rk        <= rk_nxt;
         blk       <= blk_nxt;
         data_out  <= dout_nxt;
         out_valid <= ovalid_nxt;
      end
   end

endmodule

// File: tb/tb_aes128_decrypt_core.sv
// Bench for aes128_decrypt_core: FIPS-197 vectors, handshake corner cases and random
// blocks checked against a byte-level AES model with arithmetically derived S-boxes.

module tb_aes128_decrypt_core;

   localparam logic [127:0] KB   = 128'h2b7e151628aed2a6abf7158809cf4f3c;
   localparam logic [127:0] CTB  = 128'h3925841d02dc09fbdc118597196a0b32;
   localparam logic [127:0] PTB  = 128'h3243f6a8885a308d313198a2e0370734;
   localparam logic [127:0] RKB  = 128'hd014f9a8c9ee2589e13f0cc8b6630ca6;
   localparam logic [127:0] KC   = 128'h000102030405060708090a0b0c0d0e0f;
   localparam logic [127:0] CTC  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
   localparam logic [127:0] PTC  = 128'h00112233445566778899aabbccddeeff;
   localparam logic [127:0] RKC  = 128'h13111d7fe3944a17f307a78b4d2b30c5;

   logic         clk;
   logic         rst_n;
   logic         in_valid;
   logic         in_ready;
   logic [127:0] key_in;
   logic [127:0] data_in;
   logic         out_valid;
   logic         out_ready;
   logic [127:0] data_out;

   int n_cmp = 0;
   int n_err = 0;

   logic [7:0] sb  [256];
   logic [7:0] isb [256];

   aes128_decrypt_core dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .key_in    (key_in),
      .data_in   (data_in),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .data_out  (data_out)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   // ---------------- reference model ----------------
   function automatic logic [7:0] xt(input logic [7:0] a);
      return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
   endfunction

   function automatic logic [7:0] gm(input logic [7:0] a, input logic [7:0] b);
      logic [7:0] p;
      logic [7:0] x;
      p = '0;
      x = a;
      for (int i = 0; i < 8; i++) begin
         if (b[i]) p = p ^ x;
         x = xt(x);
      end
      return p;
   endfunction

   function automatic logic [7:0] rotl8(input logic [7:0] b, input int n);
      logic [15:0] d;
      d = {b, b};
      return d[15-n -: 8];
   endfunction

   // S-box = affine transform of the GF(2^8) multiplicative inverse.
   task automatic build_sbox();
      logic [7:0] inv;
      logic [7:0] s;
      for (int x = 0; x < 256; x++) begin
         inv = '0;
         for (int y = 1; y < 256; y++)
            if (gm(8'(x), 8'(y)) == 8'h01) inv = 8'(y);
         s = inv ^ rotl8(inv, 1) ^ rotl8(inv, 2) ^ rotl8(inv, 3) ^ rotl8(inv, 4) ^ 8'h63;
         sb[x]  = s;
         isb[s] = 8'(x);
      end
   endtask

   function automatic logic [1407:0] expand_key(input logic [127:0] key);
      logic [7:0]    w [176];
      logic [7:0]    t [4];
      logic [7:0]    tmp;
      logic [7:0]    rc;
      logic [1407:0] o;
      for (int i = 0; i < 16; i++) w[i] = key[127-8*i -: 8];
      rc = 8'h01;
      for (int i = 4; i < 44; i++) begin
         for (int j = 0; j < 4; j++) t[j] = w[4*(i-1)+j];
         if (i % 4 == 0) begin
            tmp  = t[0];
            t[0] = sb[t[1]] ^ rc;
            t[1] = sb[t[2]];
            t[2] = sb[t[3]];
            t[3] = sb[tmp];
            rc   = xt(rc);
         end
         for (int j = 0; j < 4; j++) w[4*i+j] = w[4*(i-4)+j] ^ t[j];
      end
      for (int j = 0; j < 176; j++) o[1407-8*j -: 8] = w[j];
      return o;
   endfunction

   function automatic logic [127:0] aes_dec_ref(input logic [127:0] key, input logic [127:0] ct);
      logic [1407:0] ks;
      logic [7:0]    s [16];
      logic [7:0]    t [16];
      logic [7:0]    a0, a1, a2, a3;
      logic [127:0]  o;
      ks = expand_key(key);
      for (int k = 0; k < 16; k++) s[k] = ct[127-8*k -: 8] ^ ks[1407-8*(160+k) -: 8];
      for (int rnd = 9; rnd >= 0; rnd--) begin
         for (int c = 0; c < 4; c++)
            for (int r = 0; r < 4; r++)
               t[r+4*c] = isb[s[r+4*((c+4-r)%4)]] ^ ks[1407-8*(16*rnd+r+4*c) -: 8];
         if (rnd > 0) begin
            for (int c = 0; c < 4; c++) begin
               a0 = t[4*c]; a1 = t[4*c+1]; a2 = t[4*c+2]; a3 = t[4*c+3];
               s[4*c]   = gm(a0,8'h0e) ^ gm(a1,8'h0b) ^ gm(a2,8'h0d) ^ gm(a3,8'h09);
               s[4*c+1] = gm(a0,8'h09) ^ gm(a1,8'h0e) ^ gm(a2,8'h0b) ^ gm(a3,8'h0d);
               s[4*c+2] = gm(a0,8'h0d) ^ gm(a1,8'h09) ^ gm(a2,8'h0e) ^ gm(a3,8'h0b);
               s[4*c+3] = gm(a0,8'h0b) ^ gm(a1,8'h0d) ^ gm(a2,8'h09) ^ gm(a3,8'h0e);
            end
         end else begin
            s = t;
         end
      end
      for (int k = 0; k < 16; k++) o[127-8*k -: 8] = s[k];
      return o;
   endfunction

   function automatic logic [127:0] rand128();
      return {$urandom, $urandom, $urandom, $urandom};
   endfunction

   // ---------------- stimulus helpers ----------------
   task automatic wait_idle();
      int n;
      n = 0;
      while (!in_ready && n < 100) begin
         @(posedge clk); #1;
         n++;
      end
      chk("idle_before_accept", 128'(in_ready), 128'd1);
   endtask

   // Counts cycles after the accept edge until out_valid, up to a budget.
   task automatic wait_out(input bit churn, input bit chk_rk, input logic [127:0] exp_rk,
                           output int lat);
      lat = 0;
      do begin
         if (churn) begin
            key_in  = rand128();
            data_in = rand128();
         end
         @(posedge clk); #1;
         lat++;
         if (chk_rk && lat == 10) chk("rk_at_init", dut.rk, exp_rk);
      end while (!out_valid && lat < 100);
   endtask

   task automatic run_block(input logic [127:0] key, input logic [127:0] ct,
                            input logic [127:0] exp_pt, input int stall, input bit churn,
                            input bit chk_rk, input logic [127:0] exp_rk);
      int           lat;
      logic [127:0] held;
      wait_idle();
      key_in    = key;
      data_in   = ct;
      in_valid  = 1'b1;
      out_ready = (stall == 0);
      @(posedge clk); #1;
      chk("busy_after_accept", 128'(in_ready), 128'd0);
      in_valid = churn;
      wait_out(churn, chk_rk, exp_rk, lat);
      in_valid = 1'b0;
      chk("latency", 128'(lat), 128'd21);
      chk("plaintext", data_out, exp_pt);
      held = data_out;
      for (int i = 0; i < stall; i++) begin
         @(posedge clk); #1;
         chk("stall_out_valid", 128'(out_valid), 128'd1);
         chk("stall_data_stable", data_out, held);
         chk("stall_in_ready", 128'(in_ready), 128'd0);
      end
      out_ready = 1'b1;
      @(posedge clk); #1;
      chk("post_hs_out_valid", 128'(out_valid), 128'd0);
      chk("post_hs_in_ready", 128'(in_ready), 128'd1);
      chk("post_hs_data_hold", data_out, held);
      out_ready = 1'b0;
   endtask

   task automatic run_back_to_back();
      int lat;
      wait_idle();
      key_in    = KB;
      data_in   = CTB;
      in_valid  = 1'b1;
      out_ready = 1'b1;
      @(posedge clk); #1;
      key_in  = KC;
      data_in = CTC;
      wait_out(1'b0, 1'b0, '0, lat);
      chk("b2b_first_latency", 128'(lat), 128'd21);
      chk("b2b_first_pt", data_out, PTB);
      chk("b2b_no_accept_in_done", 128'(in_ready), 128'd0);
      @(posedge clk); #1;
      chk("b2b_idle_after_hs", 128'(in_ready), 128'd1);
      chk("b2b_valid_dropped", 128'(out_valid), 128'd0);
      @(posedge clk); #1;
      chk("b2b_second_accept", 128'(in_ready), 128'd0);
      in_valid = 1'b0;
      wait_out(1'b0, 1'b0, '0, lat);
      chk("b2b_second_latency", 128'(lat), 128'd21);
      chk("b2b_second_pt", data_out, PTC);
      @(posedge clk); #1;
      chk("b2b_final_idle", 128'(in_ready), 128'd1);
      out_ready = 1'b0;
   endtask

   task automatic run_reset_mid_op();
      wait_idle();
      key_in   = KC;
      data_in  = CTC;
      in_valid = 1'b1;
      @(posedge clk); #1;
      in_valid = 1'b0;
      repeat (9) begin
         @(posedge clk); #1;
      end
      rst_n = 1'b0;
      #1;
      chk("rst_in_ready", 128'(in_ready), 128'd1);
      chk("rst_out_valid", 128'(out_valid), 128'd0);
      chk("rst_data_out", data_out, 128'd0);
      repeat (2) @(posedge clk);
      #1;
      chk("rst_hold_in_ready", 128'(in_ready), 128'd1);
      rst_n = 1'b1;
      repeat (25) begin
         @(posedge clk); #1;
         if (out_valid) chk("rst_no_stale_valid", 128'(out_valid), 128'd0);
      end
      chk("rst_after_in_ready", 128'(in_ready), 128'd1);
      chk("rst_after_data_out", data_out, 128'd0);
   endtask

   // ---------------- main sequence ----------------
   initial begin
      logic [127:0] k, ct, pt;
      logic [1407:0] ks;
      int stall;
      rst_n     = 1'b0;
      in_valid  = 1'b0;
      out_ready = 1'b0;
      key_in    = '0;
      data_in   = '0;
      build_sbox();

      repeat (2) @(posedge clk);
      #1;
      chk("reset_in_ready", 128'(in_ready), 128'd1);
      chk("reset_out_valid", 128'(out_valid), 128'd0);
      chk("reset_data_out", data_out, 128'd0);
      rst_n = 1'b1;
      @(posedge clk); #1;

      run_block(KB, CTB, PTB, 0, 1'b0, 1'b1, RKB);
      run_block(KC, CTC, PTC, 0, 1'b0, 1'b1, RKC);
      run_block(KB, CTB, PTB, 5, 1'b0, 1'b0, '0);
      run_back_to_back();
      run_block(KB, CTB, PTB, 0, 1'b1, 1'b0, '0);
      run_reset_mid_op();
      run_block(KC, CTC, PTC, 0, 1'b0, 1'b0, '0);

      for (int i = 0; i < 8; i++) begin
         k     = rand128();
         ct    = rand128();
         pt    = aes_dec_ref(k, ct);
         ks    = expand_key(k);
         stall = int'($urandom_range(0, 3));
         run_block(k, ct, pt, stall, 1'b0, 1'b1, ks[127:0]);
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
